dp_pack_arbiter: RTL

Round-robin arbiter and sequencer that shares one 4+4-bit packing datapath between two requesters. It latches the winning requester's operands, drives the datapath enable/clear controls, and checks the datapath done flag within a bounded window. It returns the 8-bit packed result with a one-cycle ack, or an error pulse on timeout. It sits between requester logic and the datapath instance, and is the only driver of the datapath's en, clr, A and B inputs.

---
 rtl/dp_pack_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dp_pack_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4+4-bit packing datapath between two requesters.
// Latches the winner's operands, pulses the datapath controls and returns the result or a timeout error.
module dp_pack_arbiter #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] res,
  output logic       busy,
  output logic       dp_en,
  output logic       dp_clr,
  output logic [3:0] dp_a,
  output logic [3:0] dp_b,
  input  logic [7:0] dp_out,
  input  logic       dp_done
);

  localparam int unsigned CW = 4;
  localparam int unsigned OW = 4;
  localparam int unsigned RW = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_ABORT  = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] res_q, res_d;
  logic [OW-1:0] dp_a_q, dp_a_d;
  logic [OW-1:0] dp_b_q, dp_b_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic          busy_q, busy_d;
  logic          dp_en_q, dp_en_d;
  logic          dp_clr_q, dp_clr_d;
  logic          grant;

  // Next-state logic; outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    res_d    = '0;
    dp_a_d   = dp_a_q;
    dp_b_d   = dp_b_q;
    grant    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant   = (req0 && req1) ? rr_ptr_q : req1;
          owner_d = grant;
          dp_a_d  = grant ? a1 : a0;
          dp_b_d  = grant ? b1 : b0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // dp_done is sticky in the datapath, so it is only trusted here.
        if (dp_done) begin
          res_d   = dp_out;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_CLEAR;
      S_ABORT: state_d = S_CLEAR;
      S_CLEAR: begin
        rr_ptr_d = ~owner_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    dp_en_d  = (state_d == S_LAUNCH);
    dp_clr_d = (state_d == S_CLEAR);
    ack0_d   = (state_d == S_RESP)  && !owner_d;
    ack1_d   = (state_d == S_RESP)  &&  owner_d;
    err0_d   = (state_d == S_ABORT) && !owner_d;
    err1_d   = (state_d == S_ABORT) &&  owner_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      dp_a_q   <= '0;
      dp_b_q   <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      busy_q   <= 1'b0;
      dp_en_q  <= 1'b0;
      dp_clr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      dp_a_q   <= dp_a_d;
      dp_b_q   <= dp_b_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      busy_q   <= busy_d;
      dp_en_q  <= dp_en_d;
      dp_clr_q <= dp_clr_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign res    = res_q;
  assign busy   = busy_q;
  assign dp_en  = dp_en_q;
  assign dp_clr = dp_clr_q;
  assign dp_a   = dp_a_q;
  assign dp_b   = dp_b_q;

endmodule
